// File: rtl/run_fsm_pkg.sv
// Shared constants and helpers for the run-length detector.
package run_fsm_pkg;

    localparam logic [1:0] MODE_EITHER = 2'b00;
    localparam logic [1:0] MODE_ONES   = 2'b01;
    localparam logic [1:0] MODE_ZEROS  = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    localparam int IDLE = 0;

    function automatic int stateWidth(input int runLen, input int onehot);
        return (onehot != 0) ? 2 * runLen + 1 : $clog2(2 * runLen + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/run_length_fsm.sv
// Moore detector for RUN_LEN equal consecutive samples; the next-state logic works on a
// logical state index, wrapped by a one-hot or binary encode/decode layer.
module run_length_fsm
    import run_fsm_pkg::*;
#(
    parameter  int RUN_LEN = 4,
    parameter  int ONEHOT  = 1,
    parameter  int OVERLAP = 1,
    parameter  int CNT_W   = 8,
    localparam int SW      = stateWidth(RUN_LEN, ONEHOT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic             z,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] det_count
);

    localparam int IW = $clog2(2 * RUN_LEN + 1);
    localparam logic [IW-1:0] TERM_Z = IW'(RUN_LEN);
    localparam logic [IW-1:0] TERM_O = IW'(2 * RUN_LEN);
    localparam logic [SW-1:0] IDLE_ENC = (ONEHOT != 0) ? SW'(1) : SW'(IDLE);

    logic [SW-1:0] stateQ;
    logic [SW-1:0] nextState;
    logic [IW-1:0] curIdx;
    logic [IW-1:0] nextIdx;
    logic          illegal;
    logic          inc;

    function automatic logic hit(input logic [IW-1:0] idx, input logic [1:0] md);
        return (idx == TERM_Z && (md == MODE_EITHER || md == MODE_ZEROS)) ||
               (idx == TERM_O && (md == MODE_EITHER || md == MODE_ONES));
    endfunction

    generate
        if (ONEHOT != 0) begin : gOnehot
            always_comb begin
                curIdx  = '0;
                illegal = ($countones(stateQ) != 1);
                for (int k = 0; k < SW; k++)
                    if (stateQ[k]) curIdx = IW'(k);
            end
            always_comb begin
                nextState          = '0;
                nextState[nextIdx] = 1'b1;
            end
        end else begin : gBinary
            always_comb begin
                curIdx  = stateQ;
                illegal = (stateQ > SW'(2 * RUN_LEN));
            end
            assign nextState = nextIdx;
        end
    endgenerate

    // A polarity change, or leaving IDLE, always lands on run length 1.
    always_comb begin
        nextIdx = IW'(IDLE);
        if (!illegal) begin
            if (!w) begin
                if (curIdx >= IW'(1) && curIdx < TERM_Z)
                    nextIdx = curIdx + 1'b1;
                else if (curIdx == TERM_Z && OVERLAP != 0)
                    nextIdx = TERM_Z;
                else
                    nextIdx = IW'(1);
            end else begin
                if (curIdx > TERM_Z && curIdx < TERM_O)
                    nextIdx = curIdx + 1'b1;
                else if (curIdx == TERM_O && OVERLAP != 0)
                    nextIdx = TERM_O;
                else
                    nextIdx = TERM_Z + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stateQ <= IDLE_ENC;
        else if (en)
            stateQ <= nextState;
    end

    // Staying in a terminal state under overlap is not a new detection.
    assign inc   = en && hit(nextIdx, mode) && (nextIdx != curIdx || illegal);
    assign z     = !illegal && hit(curIdx, mode);
    assign state = stateQ;

    sat_counter #(.CNT_W(CNT_W)) uCnt (
        .clk  (clk),
        .reset(reset),
        .inc  (inc),
        .count(det_count)
    );

endmodule

// File: tb/tb_run_length_fsm.sv
// Scoreboarded bench: three configurations share one stimulus stream and a run-length model.
module tb_run_length_fsm;

    localparam int R = 4;

    typedef struct packed {
        logic [2:0][15:0] st;
        logic [2:0]       z;
        logic [2:0][7:0]  cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, w, en;
    logic [1:0] mode;

    logic [8:0] stA, stC;
    logic [3:0] stB;
    logic [7:0] cntA, cntB;
    logic [1:0] cntC;
    logic       zA, zB, zC;

    int checks = 0;
    int errors = 0;

    exp_t sbq[$];

    // Config i: 0 = onehot/overlap/8b, 1 = binary/no-overlap/8b, 2 = onehot/no-overlap/2b
    bit cfgOh[3]  = '{1, 0, 1};
    bit cfgOvl[3] = '{1, 0, 0};
    int cfgMax[3] = '{255, 255, 3};

    bit mIdle[3], mPol[3], mIll[3];
    int mLen[3], mCnt[3];

    run_length_fsm #(.RUN_LEN(R), .ONEHOT(1), .OVERLAP(1), .CNT_W(8)) dutA (
        .clk(clk), .reset(reset), .w(w), .en(en), .mode(mode), .z(zA), .state(stA), .det_count(cntA));
    run_length_fsm #(.RUN_LEN(R), .ONEHOT(0), .OVERLAP(0), .CNT_W(8)) dutB (
        .clk(clk), .reset(reset), .w(w), .en(en), .mode(mode), .z(zB), .state(stB), .det_count(cntB));
    run_length_fsm #(.RUN_LEN(R), .ONEHOT(1), .OVERLAP(0), .CNT_W(2)) dutC (
        .clk(clk), .reset(reset), .w(w), .en(en), .mode(mode), .z(zC), .state(stC), .det_count(cntC));

    always #5 clk = ~clk;

    function automatic bit polOk(input bit pol, input logic [1:0] md);
        return md == 2'b00 || (md == 2'b01 && pol) || (md == 2'b10 && !pol);
    endfunction

    // Model: a run is (polarity, length); detection when length reaches R.
    task automatic modelEdge(input bit r, input bit e, input bit wv, input logic [1:0] md);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                mIdle[i] = 1; mIll[i] = 0; mLen[i] = 0; mCnt[i] = 0;
            end else if (e) begin
                if (mIll[i]) begin
                    mIdle[i] = 1; mIll[i] = 0; mLen[i] = 0;
                end else begin
                    bit held = 0;
                    if (!mIdle[i] && mPol[i] == wv) begin
                        if (mLen[i] == R) begin
                            if (cfgOvl[i]) held = 1;
                            else mLen[i] = 1;
                        end else mLen[i]++;
                    end else begin
                        mIdle[i] = 0; mPol[i] = wv; mLen[i] = 1;
                    end
                    if (mLen[i] == R && !held && polOk(wv, md) && mCnt[i] < cfgMax[i])
                        mCnt[i]++;
                end
            end
        end
    endtask

    function automatic exp_t expect_now(input logic [1:0] md);
        exp_t x;
        x = '0;
        for (int i = 0; i < 3; i++) begin
            int idx;
            idx = mIdle[i] ? 0 : (mPol[i] ? R + mLen[i] : mLen[i]);
            if (mIll[i]) x.st[i] = 16'h0003;
            else x.st[i] = cfgOh[i] ? (16'(1) << idx) : 16'(idx);
            x.z[i]   = !mIll[i] && !mIdle[i] && mLen[i] == R && polOk(mPol[i], md);
            x.cnt[i] = 8'(mCnt[i]);
        end
        return x;
    endfunction

    // Inputs change just after a falling edge; the monitor samples on the falling edge.
    task automatic step(input bit r, input bit e, input bit wv, input logic [1:0] md);
        reset = r; en = e; w = wv; mode = md;
        @(posedge clk); #1;
        modelEdge(r, e, wv, md);
        sbq.push_back(expect_now(md));
        @(negedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [2:0][15:0] aSt;
        logic [2:0]       aZ;
        logic [2:0][7:0]  aCnt;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e    = sbq.pop_front();
                aSt  = {16'(stC), 16'(stB), 16'(stA)};
                aZ   = {zC, zB, zA};
                aCnt = {8'(cntC), cntB, cntA};
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("state%0d", i), aSt[i], e.st[i]);
                    chk($sformatf("z%0d", i), 16'(aZ[i]), 16'(e.z[i]));
                    chk($sformatf("count%0d", i), 16'(aCnt[i]), 16'(e.cnt[i]));
                end
            end
        end
    end

    initial begin : driver
        bit wv;
        logic [1:0] md;
        reset = 1; en = 1; w = 1; mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            mIdle[i] = 1; mPol[i] = 0; mIll[i] = 0; mLen[i] = 0; mCnt[i] = 0;
        end
        @(negedge clk); #1;
        step(1, 1, 1, 2'b00); step(1, 1, 1, 2'b00);

        repeat (6) step(0, 1, 1, 2'b00);                  // ones with overlap
        step(1, 1, 0, 2'b10);
        repeat (8) step(0, 1, 0, 2'b10);                  // zeros, non-overlap re-entry
        step(1, 1, 0, 2'b01);
        repeat (5) step(0, 1, 0, 2'b01);                  // masked polarity
        repeat (4) step(0, 1, 1, 2'b01);
        step(0, 0, 1, 2'b11);                             // disable: z drops, state held
        step(1, 1, 1, 2'b00);
        repeat (2) step(0, 1, 1, 2'b00);
        repeat (3) step(0, 0, 1, 2'b00);                  // enable gating
        repeat (2) step(0, 1, 1, 2'b00);
        step(1, 1, 1, 2'b00);                             // reset mid-run
        repeat (20) step(0, 1, 1, 2'b00);                 // 2-bit counter saturates

        force dutC.stateQ = 9'b000000011;                 // illegal one-hot state
        #1;
        release dutC.stateQ;
        mIll[2] = 1;
        step(0, 1, 1, 2'b00);
        step(0, 1, 0, 2'b00);

        wv = 0; md = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 2) wv = ~wv;
            if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 8, wv, md);
        end

        for (int t = 0; t < 10 && sbq.size() > 0; t++) @(negedge clk);
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
